// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : shared register map, FSM encoding and geometry for VGA      |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int FB_ADDR_W = 15;

    // Displayed area after 4x downscale of 640x480; also used by the signal generator.
    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;

    localparam logic [2:0] REG_X      = 3'd0;
    localparam logic [2:0] REG_Y      = 3'd1;
    localparam logic [2:0] REG_PIXEL  = 3'd2;
    localparam logic [2:0] REG_COL_LO = 3'd3;
    localparam logic [2:0] REG_COL_HI = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_FILL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DROP    = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SWEEP = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_fb_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_bus_ctrl : bus slave driving frame-buffer writes and colours   |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module vga_fb_bus_ctrl
    import vga_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR     = 8'hB0,
    parameter int          X_MAX         = X_MAX_DEF,
    parameter int          Y_MAX         = Y_MAX_DEF,
    parameter logic [15:0] RESET_COLOURS = 16'h00FF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           bus_addr,
    input  logic [7:0]           bus_data_in,
    input  logic                 bus_we,
    input  logic                 bus_re,
    output logic [7:0]           bus_data_out,
    output logic                 bus_data_oe,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data,
    output logic                 fb_we,
    output logic [15:0]          config_colours,
    output logic                 busy
);

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             offset;
    logic                   hit;
    logic [2:0]             reg_sel;
    logic                   wr;
    logic                   rd;
    logic                   pix_req;
    logic                   clear_req;
    logic                   sweep_end;
    logic [7:0]             x;
    logic [6:0]             y;
    logic [7:0]             last_pixel;
    logic [7:0]             col_lo;
    logic                   autoinc;
    logic [7:0]             fill;
    logic [7:0]             fill_lat;
    logic                   drop;
    logic                   pix_we;
    logic [FB_ADDR_W-1:0]   pix_addr;
    logic [7:0]             pix_data;
    logic [FB_ADDR_W-1:0]   sweep_cnt;
    logic [7:0]             rd_mux;

    always_comb begin
        offset    = bus_addr - BASE_ADDR;
        hit       = (offset < 8'd8);
        reg_sel   = offset[2:0];
        wr        = bus_we & hit;
        rd        = bus_re & hit;
        pix_req   = wr && (reg_sel == REG_PIXEL);
        clear_req = wr && (reg_sel == REG_CTRL) && bus_data_in[CTRL_CLEAR];
        sweep_end = &sweep_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_req) state_nxt = ST_SWEEP;
            ST_SWEEP: if (sweep_end) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The sweep owns the write port outright; pixel writes never coincide with it.
    always_comb begin
        busy    = (state == ST_SWEEP);
        fb_we   = busy | pix_we;
        fb_addr = busy ? sweep_cnt : pix_addr;
        fb_data = busy ? fill_lat : pix_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
            fill_lat  <= 8'h00;
        end else if ((state == ST_IDLE) && clear_req) begin
            sweep_cnt <= '0;
            fill_lat  <= fill;
        end else if (busy) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x              <= 8'h00;
            y              <= 7'h00;
            last_pixel     <= 8'h00;
            col_lo         <= RESET_COLOURS[7:0];
            config_colours <= RESET_COLOURS;
            autoinc        <= 1'b0;
            fill           <= 8'h00;
            drop           <= 1'b0;
            pix_we         <= 1'b0;
            pix_addr       <= '0;
            pix_data       <= 8'h00;
        end else begin
            pix_we <= 1'b0;
            if (wr) begin
                case (reg_sel)
                    REG_X:      x              <= bus_data_in;
                    REG_Y:      y              <= bus_data_in[6:0];
                    REG_COL_LO: col_lo         <= bus_data_in;
                    REG_COL_HI: config_colours <= {bus_data_in, col_lo};
                    REG_CTRL:   autoinc        <= bus_data_in[CTRL_AUTOINC];
                    REG_FILL:   fill           <= bus_data_in;
                    default:    ;
                endcase
            end
            if (pix_req) begin
                if (busy) begin
                    drop <= 1'b1;
                end else begin
                    pix_we     <= 1'b1;
                    pix_addr   <= {y, x};
                    pix_data   <= bus_data_in;
                    last_pixel <= bus_data_in;
                    if (autoinc) begin
                        if (x >= X_LIM) begin
                            x <= 8'h00;
                            y <= (y >= Y_LIM) ? 7'h00 : y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
            end
            if (rd && (reg_sel == REG_STATUS)) begin
                drop <= 1'b0;
            end
            if (state == ST_DONE) begin
                x <= 8'h00;
                y <= 7'h00;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_X:      rd_mux = x;
            REG_Y:      rd_mux = {1'b0, y};
            REG_PIXEL:  rd_mux = last_pixel;
            REG_COL_LO: rd_mux = col_lo;
            REG_COL_HI: rd_mux = config_colours[15:8];
            REG_CTRL:   rd_mux[CTRL_AUTOINC] = autoinc;
            REG_FILL:   rd_mux = fill;
            REG_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DROP] = drop;
            end
            default:    rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_data_out <= 8'h00;
            bus_data_oe  <= 1'b0;
        end else begin
            bus_data_oe  <= rd;
            bus_data_out <= rd ? rd_mux : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_fb_bus_ctrl : randomized bench with a register-level model     |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module tb_vga_fb_bus_ctrl;
    import vga_pkg::*;

    localparam logic [7:0] BASE = 8'hB0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bus_addr = 8'h00;
    logic [7:0]  bus_data_in = 8'h00;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic [15:0] config_colours;
    logic        busy;

    always #5 clk = ~clk;

    vga_fb_bus_ctrl dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
        .bus_we(bus_we), .bus_re(bus_re), .bus_data_out(bus_data_out),
        .bus_data_oe(bus_data_oe), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .config_colours(config_colours), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents as plain integers
    int mx, my, mauto, mfill, mcol_lo, mcol, mpix, mdrop;
    int exp_q[$];
    bit sweep_on = 1'b0;
    int sweep_next, sweep_fill, sweep_writes, sweep_bad, busy_cycles;
    int popped;

    task automatic model_reset();
        mx = 0; my = 0; mauto = 0; mfill = 0;
        mcol_lo = 'hFF; mcol = 'h00FF; mpix = 0; mdrop = 0;
    endtask

    always @(negedge clk) begin
        if (sweep_on) begin
            if (busy) busy_cycles++;
            if (fb_we) begin
                sweep_writes++;
                if (int'(fb_addr) != sweep_next || int'(fb_data) != sweep_fill) sweep_bad++;
                sweep_next++;
            end
        end else if (fb_we) begin
            if (exp_q.size() == 0) begin
                chk("fb_we_unexpected", 1, 0);
            end else begin
                popped = exp_q.pop_front();
                chk("fb_write", int'({fb_addr, fb_data}), popped);
            end
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_data_in = d; bus_we = 1'b1;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output int d, output int oe);
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        @(posedge clk);
        #1;
        bus_re = 1'b0;
        d  = int'(bus_data_out);
        oe = int'(bus_data_oe);
    endtask

    // Idle-mode register write, mirrored into the model
    task automatic reg_wr(input int off, input int d);
        bus_wr(BASE + 8'(off), 8'(d));
        case (off)
            0: mx = d;
            1: my = d % 128;
            2: begin
                exp_q.push_back((my * 256 + mx) * 256 + d);
                mpix = d;
                if (mauto != 0) begin
                    if (mx >= 159) begin
                        mx = 0;
                        my = (my >= 119) ? 0 : my + 1;
                    end else begin
                        mx = mx + 1;
                    end
                end
            end
            3: mcol_lo = d;
            4: mcol = d * 256 + mcol_lo;
            5: mauto = d % 2;
            6: mfill = d;
            default: ;
        endcase
    endtask

    task automatic reg_rd_chk(input int off);
        int d, oe, e;
        bus_rd(BASE + 8'(off), d, oe);
        case (off)
            0: e = mx;
            1: e = my;
            2: e = mpix;
            3: e = mcol_lo;
            4: e = mcol / 256;
            5: e = mauto;
            6: e = mfill;
            default: e = mdrop * 2;
        endcase
        chk("rd_oe", oe, 1);
        chk($sformatf("rd_reg%0d", off), d, e);
        if (off == 7) mdrop = 0;
    endtask

    function automatic logic [7:0] oow_addr();
        logic [7:0] a;
        do a = 8'($urandom_range(0, 255)); while (8'(a - BASE) < 8'd8);
        return a;
    endfunction

    initial begin
        int d, oe;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_colours", int'(config_colours), 'h00FF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_oe", int'(bus_data_oe), 0);
        reg_rd_chk(7);
        reg_rd_chk(4);
        chk("rd_oe_drop", int'(bus_data_oe), 1);

        // single pixel
        reg_wr(0, 5); reg_wr(1, 7); reg_wr(2, 'hE3);
        chk("pix_we", int'(fb_we), 1);
        chk("pix_addr", int'(fb_addr), 'h0705);
        chk("pix_data", int'(fb_data), 'hE3);

        // autoinc wrap at both corners
        reg_wr(5, 1); reg_wr(0, 159); reg_wr(1, 119);
        reg_wr(2, 'h1C);
        chk("wrap1_addr", int'(fb_addr), 'h779F);
        reg_rd_chk(0); reg_rd_chk(1);
        reg_wr(2, 'h1C);
        chk("wrap2_addr", int'(fb_addr), 'h0000);
        reg_rd_chk(0);
        chk("x_after_wrap", mx, 1);

        // colour commit
        reg_wr(3, 'h34);
        chk("col_lo_only", int'(config_colours), 'h00FF);
        reg_wr(4, 'h12);
        chk("col_commit", int'(config_colours), 'h1234);

        // full clear sweep
        reg_wr(6, 'hAA);
        sweep_next = 0; sweep_fill = 'hAA; sweep_writes = 0; sweep_bad = 0; busy_cycles = 0;
        bus_wr(BASE + 8'd5, 8'h03);
        mauto = 1;
        sweep_on = 1'b1;
        chk("busy_start", int'(busy), 1);
        repeat (100) @(negedge clk);
        bus_wr(BASE + 8'd2, 8'h55);
        bus_wr(BASE + 8'd6, 8'h11); mfill = 'h11;
        bus_wr(BASE + 8'd5, 8'h03);
        bus_rd(BASE + 8'd7, d, oe);
        chk("status_mid", d, 'h03);
        for (int i = 0; i < 40000 && busy; i++) @(negedge clk);
        chk("sweep_timeout", int'(busy), 0);
        sweep_on = 1'b0;
        chk("busy_cycles", busy_cycles, 32768);
        chk("sweep_writes", sweep_writes, 32768);
        chk("sweep_bad", sweep_bad, 0);
        mx = 0; my = 0; mdrop = 0;
        reg_rd_chk(7); reg_rd_chk(0); reg_rd_chk(1); reg_rd_chk(6);

        // reset during a sweep
        bus_wr(BASE + 8'd5, 8'h02);
        sweep_next = 0; sweep_fill = 'h11; sweep_writes = 0; sweep_bad = 0; busy_cycles = 0;
        sweep_on = 1'b1;
        repeat (1000) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_busy", int'(busy), 0);
        sweep_on = 1'b0;
        chk("abort_sweep_bad", sweep_bad, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("abort_colours", int'(config_colours), 'h00FF);
        reg_wr(0, 3); reg_wr(1, 2); reg_wr(2, 'h77);
        chk("post_rst_we", int'(fb_we), 1);
        chk("post_rst_addr", int'(fb_addr), 'h0203);

        // randomized idle traffic
        for (int i = 0; i < 400; i++) begin
            int op, v;
            op = int'($urandom_range(0, 9));
            v  = int'($urandom_range(0, 255));
            case (op)
                0: reg_wr(0, ($urandom_range(0, 2) == 0) ? 150 + int'($urandom_range(0, 105)) : v);
                1: reg_wr(1, ($urandom_range(0, 2) == 0) ? 115 + int'($urandom_range(0, 12)) : v);
                2, 3: reg_wr(2, v);
                4: reg_wr(5, v % 2);
                5: reg_wr(int'($urandom_range(3, 4)), v);
                6: reg_wr(6, v);
                7: bus_wr(oow_addr(), 8'(v));
                8: reg_rd_chk(int'($urandom_range(0, 7)));
                default: begin
                    bus_rd(oow_addr(), d, oe);
                    chk("oow_oe", oe, 0);
                end
            endcase
        end
        for (int r = 0; r < 8; r++) reg_rd_chk(r);
        chk("final_colours", int'(config_colours), mcol);
        repeat (2) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_bus_ctrl.md
Name: vga_fb_bus_ctrl

Overview:
- Processor-bus slave that owns the write side of the VGA frame buffer, directly upstream of the VGA signal generator.
- Turns CPU register writes into single-cycle frame-buffer writes.
- Provides auto-increment pixel streaming and a hardware clear-screen sweep.
- Holds the 16-bit colour configuration word that the signal generator consumes.

Parameters:
- BASE_ADDR, 8'hB0, bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+7.
- X_MAX, 159, last displayed column (640/4 - 1); auto-increment wrap point.
- Y_MAX, 119, last displayed row (480/4 - 1); auto-increment wrap point.
- RESET_COLOURS, 16'h00FF, reset value of CONFIG_COLOURS.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- BUS_ADDR  in  8  processor bus address.
- BUS_DATA_IN  in  8  write data.
- BUS_WE  in  1  write strobe, one cycle per write.
- BUS_RE  in  1  read strobe, one cycle per read.
- BUS_DATA_OUT  out  8  read data, valid the cycle after BUS_RE.
- BUS_DATA_OE  out  1  high for exactly the cycle BUS_DATA_OUT is valid.
- FB_ADDR  out  15  frame-buffer write address {Y[6:0], X[7:0]}.
- FB_DATA  out  8  frame-buffer write data.
- FB_WE  out  1  frame-buffer write enable.
- CONFIG_COLOURS  out  16  colour configuration word to the VGA signal generator.
- BUSY  out  1  clear sweep in progress.

Behaviour:
- Reset values: all outputs 0, except CONFIG_COLOURS = RESET_COLOURS. X = 0, Y = 0, FILL = 0, CTRL = 0, sticky DROP = 0, COL_LO shadow = RESET_COLOURS[7:0]. FSM = IDLE.
- Register offsets (hit when BUS_ADDR - BASE_ADDR is in 0..7):
  - 0 X: R/W, 8 bits.
  - 1 Y: R/W, 7 bits stored; write bit 7 ignored, reads as 0.
  - 2 PIXEL: W; triggers a pixel write. Reads return the last written pixel.
  - 3 COL_LO: W to shadow only; reads return the shadow.
  - 4 COL_HI: W; commits {BUS_DATA_IN, shadow} to CONFIG_COLOURS in one cycle.
  - 5 CTRL: bit0 AUTOINC (R/W); bit1 CLEAR (write-1 starts sweep, self-clearing, reads 0).
  - 6 FILL: R/W, clear colour.
  - 7 STATUS: RO; bit0 BUSY, bit1 DROP. A read clears DROP on the cycle after BUS_RE.
- Writes or reads outside the 8-register window: no effect, BUS_DATA_OE stays 0.
- Read latency: 1 cycle, registered.
- Pixel write in IDLE:
  - Cycle after the PIXEL write: FB_WE = 1 for exactly 1 cycle, FB_ADDR = {Y, X} sampled at the write, FB_DATA = written value.
  - If AUTOINC = 1, X/Y advance in that same cycle: X < X_MAX gives X + 1. X >= X_MAX gives X = 0 and Y advances; Y >= Y_MAX gives Y = 0, otherwise Y + 1.
  - Out-of-range X (> X_MAX) is still written to the buffer, then wraps to 0.
- A simultaneous X/Y write and PIXEL write cannot occur (one bus transaction per cycle). A PIXEL write uses the X/Y values registered before it.
- FSM states:
  - IDLE: a CLEAR write goes to SWEEP; the sweep counter is loaded with 0 and BUSY = 1 from the next cycle.
  - SWEEP: FB_WE = 1 every cycle, FB_ADDR = counter, FB_DATA = FILL latched at start. Counter increments by 1. Addresses 0..32767 are all written, 32768 cycles. At 32767 the FSM goes to DONE.
  - DONE: one cycle; BUSY drops; X = 0, Y = 0; then IDLE.
- While BUSY:
  - PIXEL writes are dropped and set DROP.
  - CLEAR writes are ignored; they do not restart the sweep and do not set DROP.
  - X, Y, FILL, COL and CTRL.AUTOINC writes are accepted. A FILL change does not affect the current sweep.
- RESET asserted mid-sweep: immediate abort; FB_WE = 0 asynchronously; FSM = IDLE; the buffer is left partially cleared.
- CONFIG_COLOURS never changes mid-cycle-pair: only a COL_HI write updates it.

Decomposition:
- Shared package vga_pkg holds:
  - register offset constants REG_X..REG_STATUS;
  - CTRL/STATUS bit indices;
  - FSM state encoding (IDLE, SWEEP, DONE);
  - FB_ADDR_W = 15;
  - geometry constants X_MAX_DEF / Y_MAX_DEF, also used by the signal generator's 4x downscale.
- No sub-module: the register file, 15-bit sweep counter and FSM live inline.

Test Plan:
- Reset, then read STATUS and COL_HI -> STATUS = 8'h00; CONFIG_COLOURS = 16'h00FF; FB_WE never high.
- Write X = 5, Y = 7, PIXEL = 8'hE3 -> the next cycle has FB_WE = 1 for one cycle, FB_ADDR = 15'h0705, FB_DATA = 8'hE3.
- AUTOINC = 1, X = 159, Y = 119, PIXEL = 8'h1C twice:
  - first write at 15'h779F;
  - second write at 15'h0000;
  - X = 0 and Y = 0 after the first write, X = 1 after the second.
- FILL = 8'hAA, CLEAR:
  - BUSY is high for 32768 cycles;
  - FB_WE is continuously high with addresses 0..32767, all with data 8'hAA;
  - a PIXEL write issued mid-sweep leaves no FB_WE outside the sweep and gives STATUS = 8'h03;
  - a second STATUS read after completion returns 8'h00.
- COL_LO = 8'h34, then COL_HI = 8'h12 -> CONFIG_COLOURS stays 16'h00FF after the COL_LO write and becomes 16'h1234 the cycle after the COL_HI write.
- RESET pulsed at sweep cycle 1000 -> FB_WE = 0 and BUSY = 0 immediately; a following PIXEL write is accepted normally.
